// File: rtl/door_sensor_gen.sv
// -----------------------------------------------------------------------------
// door_sensor_gen
//
// Stands in for the two doorway beam sensors. Queued doorway-event commands
// (enter, exit, balk-in, balk-out) are replayed as ordered, timed pulse pairs
// on x1 (outer beam) and x2 (inner beam). The block also tracks a reference
// occupancy count and the lamp state that the lamp controller should show.
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  asynchronous reset, active-low
//   cmd_valid  in   1  command present
//   cmd_type   in   2  00 enter, 01 exit, 10 balk-in, 11 balk-out
//   cmd_ready  out  1  command FIFO not full (0 while in reset)
//   x1         out  1  outer sensor line, registered
//   x2         out  1  inner sensor line, registered
//   busy       out  1  event in progress or commands queued, registered
//   done       out  1  one-cycle pulse after the last quiet cycle of an event
//   occ        out  8  reference occupancy count, saturating 0..255
//   lamp_exp   out  1  expected lamp state (occ != 0), registered
// -----------------------------------------------------------------------------
module door_sensor_gen #(
  parameter int unsigned PW    = 2,
  parameter int unsigned GAP   = 1,
  parameter int unsigned TAIL  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  output logic       cmd_ready,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic [7:0] occ,
  output logic       lamp_exp
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned MAXP = (PW > GAP) ? ((PW > TAIL) ? PW : TAIL)
                                            : ((GAP > TAIL) ? GAP : TAIL);
  // The phase counter counts down from len-1 to 0.
  localparam int unsigned CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] LD_PW   = CW'(PW - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(GAP - 1);
  localparam logic [CW-1:0] LD_TAIL = CW'(TAIL - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] T_ENTER = 2'b00;
  localparam logic [1:0] T_EXIT  = 2'b01;
  localparam logic [1:0] T_BIN   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_GAP  = 3'd2,
    S_PH2  = 3'd3,
    S_TAIL = 3'd4
  } state_e;

  // First pulse is on the outer beam for enter and balk-in.
  function automatic logic first_is_x1(input logic [1:0] t);
    return (t == T_ENTER) || (t == T_BIN);
  endfunction

  // Second pulse is on the outer beam for exit and balk-in.
  function automatic logic second_is_x1(input logic [1:0] t);
    return (t == T_EXIT) || (t == T_BIN);
  endfunction

  // Occupancy update on event completion, saturating at both ends.
  function automatic logic [7:0] occ_step(input logic [7:0] o, input logic [1:0] t);
    logic [7:0] r;
    case (t)
      T_ENTER: r = (o == 8'hFF) ? o : o + 8'd1;
      T_EXIT:  r = (o == 8'h00) ? o : o - 8'd1;
      default: r = o;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] ph_q, ph_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    cur_q, cur_d;
  logic          ready_q, ready_d;
  logic          x1_q, x1_d, x2_q, x2_d;
  logic          fin_q, fin_d;
  logic [1:0]    fin_type_q, fin_type_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [7:0]    occ_q, occ_d;
  logic          lamp_q, lamp_d;

  logic          push_s, pop_s, empty_s, last_s;
  logic [1:0]    head_s;
  logic [AW:0]   cnt_next_s;

  assign push_s  = cmd_valid && ready_q;
  assign empty_s = (wr_q == rd_q);
  assign head_s  = mem_q[rd_q[AW-1:0]];
  assign last_s  = (ph_q == '0);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= cmd_type;
    end
  end

  // Event sequencer: next state, phase counter reload and FIFO pop.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = S_PH1;
          ph_d    = LD_PW;
        end else begin
          ph_d    = '0;
        end
      end
      S_PH1: begin
        if (last_s) begin
          state_d = S_GAP;
          ph_d    = LD_GAP;
        end else begin
          ph_d    = ph_q - CW'(1);
        end
      end
      S_GAP: begin
        if (last_s) begin
          state_d = S_PH2;
          ph_d    = LD_PW;
        end else begin
          ph_d    = ph_q - CW'(1);
        end
      end
      S_PH2: begin
        if (last_s) begin
          state_d = S_TAIL;
          ph_d    = LD_TAIL;
        end else begin
          ph_d    = ph_q - CW'(1);
        end
      end
      S_TAIL: begin
        if (last_s) begin
          // Chain straight into the next event when one is queued.
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = S_PH1;
            ph_d    = LD_PW;
          end else begin
            state_d = S_IDLE;
            ph_d    = '0;
          end
        end else begin
          ph_d    = ph_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  // FIFO pointers and ready flag; a full FIFO refuses pushes even on a pop cycle.
  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    cur_d      = cur_q;
    if (push_s) begin
      wr_d = wr_q + (AW + 1)'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d  = rd_q + (AW + 1)'(1);
      cur_d = head_s;
    end else begin
      rd_d  = rd_q;
      cur_d = cur_q;
    end
    cnt_next_s = wr_d - rd_d;
    ready_d    = (cnt_next_s != FULL_CNT);
  end

  // Sensor lines follow the current phase one cycle later, from registers.
  always_comb begin
    x1_d = 1'b0;
    x2_d = 1'b0;
    case (state_q)
      S_PH1: begin
        x1_d = first_is_x1(cur_q);
        x2_d = !first_is_x1(cur_q);
      end
      S_PH2: begin
        x1_d = second_is_x1(cur_q);
        x2_d = !second_is_x1(cur_q);
      end
      default: begin
        x1_d = 1'b0;
        x2_d = 1'b0;
      end
    endcase
  end

  // Completion is noted as TAIL ends, then reported (done, occ) one edge later
  // so that it lines up with the delayed sensor lines.
  always_comb begin
    fin_d      = (state_q == S_TAIL) && last_s;
    fin_type_d = cur_q;
    done_d     = fin_q;
    if (fin_q) begin
      occ_d = occ_step(occ_q, fin_type_q);
    end else begin
      occ_d = occ_q;
    end
    lamp_d = (occ_d != 8'd0);
    busy_d = (state_d != S_IDLE) || !empty_s;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cur_q      <= 2'b00;
      ready_q    <= 1'b0;
      x1_q       <= 1'b0;
      x2_q       <= 1'b0;
      fin_q      <= 1'b0;
      fin_type_q <= 2'b00;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      occ_q      <= 8'd0;
      lamp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cur_q      <= cur_d;
      ready_q    <= ready_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      fin_q      <= fin_d;
      fin_type_q <= fin_type_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      occ_q      <= occ_d;
      lamp_q     <= lamp_d;
    end
  end

  assign cmd_ready = ready_q;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign occ       = occ_q;
  assign lamp_exp  = lamp_q;

endmodule
